ssd_scan_ctrl: RTL and testbench

Four-digit seven/fourteen-segment scan controller. It sits directly upstream of the BCD-to-segment decoder. It holds a four-digit display value and time-multiplexes one 4-bit digit code per scan slot onto `bcd_out`, which feeds the decoder. It also drives the active-low digit enables, optionally blanks leading zeros, and accepts new display values with a load/ack handshake that applies updates only at frame boundaries, so the display never shows a torn value.

---
 rtl/ssd_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
//
// Four-digit scan controller that feeds a BCD-to-segment decoder. It holds
// the displayed value in a shadow register and presents one 4-bit digit code
// per scan slot. It drives active-low digit enables and can blank leading
// zeros. New values enter through a pending register and reach the shadow
// register only at a frame boundary, so a frame never shows a torn value.
//
// Ports:
//   clk        in   system clock; all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   digits_in  in   [15:12]=digit3 (leftmost) ... [3:0]=digit0 (rightmost)
//   load       in   capture digits_in into the pending register this edge
//   blank_lz   in   leading-zero blanking enable (registered internally)
//   load_ack   out  one-cycle pulse: pending value moved into the display
//   frame_tick out  one-cycle pulse: scan wrapped from digit 3 to digit 0
//   digit_sel  out  current scan index
//   bcd_out    out  digit code for the current slot
//   ssd_ctl    out  active-low digit enables (one-hot-low or all ones)
//
// Every output is taken from registers. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
  parameter int DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [1:0]  digit_sel,
  output logic [3:0]  bcd_out,
  output logic [3:0]  ssd_ctl
);

  logic [DIV_WIDTH-1:0] divCnt_q, divCnt_d;
  logic [1:0]           digitSel_q, digitSel_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [15:0]          pendVal_q, pendVal_d;
  logic                 pend_q, pend_d;
  logic                 blank_q, blank_d;
  logic                 loadAck_q, loadAck_d;
  logic                 frameTick_q, frameTick_d;

  logic                 scanTick;
  logic                 frameEdge;
  logic [3:0]           leadZero;
  logic                 blanked;

  // Next-state logic. A frame boundary is the last divider count of slot 3.
  // At that edge the pending value (as it was before the edge) moves into
  // the shadow register. A load on the same edge refills the pending
  // register afterwards, so the transfer and the new capture do not collide.
  always_comb begin
    scanTick    = &divCnt_q;
    frameEdge   = scanTick && (digitSel_q == 2'd3);

    divCnt_d    = divCnt_q + DIV_WIDTH'(1);
    digitSel_d  = scanTick ? digitSel_q + 2'd1 : digitSel_q;
    shadow_d    = shadow_q;
    pendVal_d   = pendVal_q;
    pend_d      = pend_q;
    blank_d     = blank_lz;
    loadAck_d   = 1'b0;
    frameTick_d = frameEdge;

    if (frameEdge && pend_q) begin
      shadow_d  = pendVal_q;
      loadAck_d = 1'b1;
      pend_d    = 1'b0;
    end

    if (load) begin
      pendVal_d = digits_in;
      pend_d    = 1'b1;
    end
  end

  // State registers. Reset takes priority over load and over the frame
  // boundary, so a pending value is discarded and produces no acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divCnt_q    <= '0;
      digitSel_q  <= 2'd0;
      shadow_q    <= 16'h0000;
      pendVal_q   <= 16'h0000;
      pend_q      <= 1'b0;
      blank_q     <= 1'b0;
      loadAck_q   <= 1'b0;
      frameTick_q <= 1'b0;
    end else begin
      divCnt_q    <= divCnt_d;
      digitSel_q  <= digitSel_d;
      shadow_q    <= shadow_d;
      pendVal_q   <= pendVal_d;
      pend_q      <= pend_d;
      blank_q     <= blank_d;
      loadAck_q   <= loadAck_d;
      frameTick_q <= frameTick_d;
    end
  end

  // Leading-zero detection works from the left. Digit k counts as a leading
  // zero only when it and every digit to its left are zero. Digit 0 is never
  // blanked, so an all-zero value still shows a single 0.
  always_comb begin
    leadZero[3] = (shadow_q[15:12] == 4'h0);
    leadZero[2] = leadZero[3] && (shadow_q[11:8] == 4'h0);
    leadZero[1] = leadZero[2] && (shadow_q[7:4] == 4'h0);
    leadZero[0] = 1'b0;
    blanked     = blank_q && leadZero[digitSel_q];
  end

  // Slot output. A blanked digit keeps its code on bcd_out, and only the
  // enable is suppressed.
  always_comb begin
    bcd_out = 4'h0;
    ssd_ctl = 4'b1111;
    case (digitSel_q)
      2'd0: begin bcd_out = shadow_q[3:0];   ssd_ctl = 4'b1110; end
      2'd1: begin bcd_out = shadow_q[7:4];   ssd_ctl = 4'b1101; end
      2'd2: begin bcd_out = shadow_q[11:8];  ssd_ctl = 4'b1011; end
      2'd3: begin bcd_out = shadow_q[15:12]; ssd_ctl = 4'b0111; end
      default: begin bcd_out = 4'h0;         ssd_ctl = 4'b1111; end
    endcase
    if (blanked) begin
      ssd_ctl = 4'b1111;
    end
  end

  assign load_ack   = loadAck_q;
  assign frame_tick = frameTick_q;
  assign digit_sel  = digitSel_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_ctrl
//
// Bench for ssd_scan_ctrl with DIV_WIDTH=2, which gives 4 clocks per slot
// and 16 clocks per frame. Every value written with load is pushed onto a
// queue of expected display values. Each load_ack pops the oldest entry and
// checks it against the new display. A table of blanking vectors covers the
// per-slot output, and hand-written sequences cover the multi-cycle cases.
// ---------------------------------------------------------------------------
module tb_ssd_scan_ctrl;

  localparam int DW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        load;
  logic        blank_lz;
  logic        load_ack;
  logic        frame_tick;
  logic [1:0]  digit_sel;
  logic [3:0]  bcd_out;
  logic [3:0]  ssd_ctl;

  int          vectorCount = 0;
  int          missCount   = 0;
  int          ackCount    = 0;
  int          ackBase;
  logic [15:0] curShadow;
  logic [15:0] expQ[$];
  logic [3:0]  ctlTable [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct {
    logic [15:0] shadowVal;
    logic        blank;
    logic [1:0]  slot;
    logic [3:0]  expBcd;
    logic [3:0]  expCtl;
  } vec_t;

  vec_t vecs[$];

  ssd_scan_ctrl #(.DIV_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .digit_sel  (digit_sel),
    .bcd_out    (bcd_out),
    .ssd_ctl    (ssd_ctl)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Hard stop in case a sequence loses its way.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 unit after the edge. Any acknowledge is
  // checked against the oldest entry in the expected-display queue.
  task automatic step();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (load_ack === 1'b1) begin
      ackCount++;
      checkOutput("ackWithFrameTick", 16'(frame_tick), 16'd1);
      checkOutput("ackDigitSel", 16'(digit_sel), 16'd0);
      checkOutput("ackExpected", 16'(expQ.size() != 0), 16'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("ackDigit0", 16'(bcd_out), 16'(e[3:0]));
      end
    end
  endtask

  // Record a loaded value. Without newEntry the value overwrites a pending
  // value that has not been acknowledged yet.
  task automatic noteLoad(input logic [15:0] v, input bit newEntry);
    if (newEntry || expQ.size() == 0) expQ.push_back(v);
    else expQ[expQ.size()-1] = v;
  endtask

  task automatic waitAck(input int maxCycles);
    int n = 0;
    while (load_ack !== 1'b1 && n < maxCycles) begin
      step();
      n++;
    end
    checkOutput("ackArrived", 16'(load_ack === 1'b1), 16'd1);
  endtask

  task automatic waitSel(input logic [1:0] s, input int maxCycles);
    int n = 0;
    while (digit_sel !== s && n < maxCycles) begin
      step();
      n++;
    end
    checkOutput("selReached", 16'(digit_sel), 16'(s));
  endtask

  task automatic waitFrame(input int maxCycles);
    int n = 0;
    while (frame_tick !== 1'b1 && n < maxCycles) begin
      step();
      n++;
    end
    checkOutput("frameReached", 16'(frame_tick), 16'd1);
  endtask

  // Check one full unblanked frame, starting from the slot-0 cycle.
  task automatic checkFrame(input logic [15:0] exp);
    int          s;
    logic [15:0] sh;
    for (int i = 0; i < 16; i++) begin
      s  = i / 4;
      sh = exp >> (4 * s);
      checkOutput($sformatf("frameSel[%0d]", i), 16'(digit_sel), 16'(s));
      checkOutput($sformatf("frameBcd[%0d]", i), 16'(bcd_out), 16'(sh[3:0]));
      checkOutput($sformatf("frameCtl[%0d]", i), 16'(ssd_ctl), 16'(ctlTable[s]));
      step();
    end
  endtask

  // Apply one blanking vector. Load the value if it differs from the current
  // display, then wait for the slot and compare the slot outputs.
  task automatic applyStimulus(input int idx);
    blank_lz = vecs[idx].blank;
    if (vecs[idx].shadowVal != curShadow) begin
      digits_in = vecs[idx].shadowVal;
      load      = 1'b1;
      noteLoad(vecs[idx].shadowVal, 1'b0);
      step();
      load      = 1'b0;
      waitAck(40);
      curShadow = vecs[idx].shadowVal;
    end else begin
      step();
    end
    waitSel(vecs[idx].slot, 20);
    checkOutput($sformatf("blankBcd[%0d]", idx), 16'(bcd_out), 16'(vecs[idx].expBcd));
    checkOutput($sformatf("blankCtl[%0d]", idx), 16'(ssd_ctl), 16'(vecs[idx].expCtl));
  endtask

  initial begin
    vecs.push_back(vec_t'{16'h0050, 1'b1, 2'd0, 4'h0, 4'b1110});
    vecs.push_back(vec_t'{16'h0050, 1'b1, 2'd1, 4'h5, 4'b1101});
    vecs.push_back(vec_t'{16'h0050, 1'b1, 2'd2, 4'h0, 4'b1111});
    vecs.push_back(vec_t'{16'h0050, 1'b1, 2'd3, 4'h0, 4'b1111});
    vecs.push_back(vec_t'{16'h0000, 1'b1, 2'd0, 4'h0, 4'b1110});
    vecs.push_back(vec_t'{16'h0000, 1'b1, 2'd1, 4'h0, 4'b1111});
    vecs.push_back(vec_t'{16'h0000, 1'b1, 2'd2, 4'h0, 4'b1111});
    vecs.push_back(vec_t'{16'h0000, 1'b1, 2'd3, 4'h0, 4'b1111});
    vecs.push_back(vec_t'{16'h0000, 1'b0, 2'd3, 4'h0, 4'b0111});
    vecs.push_back(vec_t'{16'hA000, 1'b1, 2'd0, 4'h0, 4'b1110});
    vecs.push_back(vec_t'{16'hA000, 1'b1, 2'd1, 4'h0, 4'b1101});
    vecs.push_back(vec_t'{16'hA000, 1'b1, 2'd2, 4'h0, 4'b1011});
    vecs.push_back(vec_t'{16'hA000, 1'b1, 2'd3, 4'hA, 4'b0111});

    // Reset state.
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;
    blank_lz  = 1'b0;
    repeat (3) step();
    checkOutput("rstCtl", 16'(ssd_ctl), 16'b1110);
    checkOutput("rstBcd", 16'(bcd_out), 16'h0);
    checkOutput("rstAck", 16'(load_ack), 16'd0);
    checkOutput("rstFrameTick", 16'(frame_tick), 16'd0);
    checkOutput("rstSel", 16'(digit_sel), 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("selHold[%0d]", i), 16'(digit_sel), 16'd0);
    end
    step();
    checkOutput("firstScanSel", 16'(digit_sel), 16'd1);
    checkOutput("firstScanCtl", 16'(ssd_ctl), 16'b1101);

    // Single load of 1234.
    ackBase   = ackCount;
    digits_in = 16'h1234;
    load      = 1'b1;
    noteLoad(16'h1234, 1'b0);
    step();
    load = 1'b0;
    waitAck(40);
    checkFrame(16'h1234);
    checkOutput("frameTickNoAck", 16'(frame_tick), 16'd1);
    checkOutput("noAckNoPend", 16'(load_ack), 16'd0);
    checkOutput("oneAck1234", 16'(ackCount - ackBase), 16'd1);
    curShadow = 16'h1234;

    // Leading-zero blanking vectors.
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    // Two loads in one frame: only the last value is shown.
    blank_lz = 1'b0;
    step();
    waitFrame(40);
    ackBase   = ackCount;
    digits_in = 16'h1111;
    load      = 1'b1;
    noteLoad(16'h1111, 1'b0);
    step();
    load = 1'b0;
    step();
    digits_in = 16'h2222;
    load      = 1'b1;
    noteLoad(16'h2222, 1'b0);
    step();
    load = 1'b0;
    waitAck(40);
    checkFrame(16'h2222);
    checkOutput("oneAck2222", 16'(ackCount - ackBase), 16'd1);

    // Load on the boundary edge while 5555 is pending.
    ackBase   = ackCount;
    digits_in = 16'h5555;
    load      = 1'b1;
    noteLoad(16'h5555, 1'b1);
    step();
    load = 1'b0;
    repeat (14) step();
    checkOutput("preBoundarySel", 16'(digit_sel), 16'd3);
    checkOutput("preBoundaryNoAck", 16'(load_ack), 16'd0);
    digits_in = 16'h9999;
    load      = 1'b1;
    noteLoad(16'h9999, 1'b1);
    step();
    load = 1'b0;
    checkOutput("bndAck1", 16'(load_ack), 16'd1);
    checkFrame(16'h5555);
    checkOutput("bndAck2", 16'(load_ack), 16'd1);
    checkFrame(16'h9999);
    checkOutput("bndAckCount", 16'(ackCount - ackBase), 16'd2);

    // Reset mid-frame with 7777 pending and load held during reset.
    digits_in = 16'h7777;
    load      = 1'b1;
    noteLoad(16'h7777, 1'b1);
    step();
    load = 1'b0;
    waitSel(2'd2, 20);
    rst_n = 1'b0;
    load  = 1'b1;
    step();
    expQ.delete();
    rst_n = 1'b1;
    load  = 1'b0;
    checkOutput("midRstSel", 16'(digit_sel), 16'd0);
    checkOutput("midRstBcd", 16'(bcd_out), 16'h0);
    checkOutput("midRstCtl", 16'(ssd_ctl), 16'b1110);
    checkOutput("midRstAck", 16'(load_ack), 16'd0);
    checkOutput("midRstFrameTick", 16'(frame_tick), 16'd0);
    ackBase = ackCount;
    for (int i = 0; i < 32; i++) begin
      step();
      checkOutput($sformatf("postRstBcd[%0d]", i), 16'(bcd_out), 16'h0);
      checkOutput($sformatf("postRstTick[%0d]", i), 16'(frame_tick),
                  16'((i % 16) == 15));
    end
    checkOutput("postRstNoAck", 16'(ackCount - ackBase), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
